// File: rtl/semimips_hazard_pkg.sv
// Shared types and helpers for the semiMIPS hazard/stall logic.
package semimips_hazard_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MDUWAIT = 1'b1
  } mdu_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Down-counter width needed to hold the MDU latency value itself.
  function automatic int mdu_cnt_width(input int latency);
    return (latency < 2) ? 1 : $clog2(latency + 1);
  endfunction

  // $0 is hardwired, so a write to it can never create a dependency.
  function automatic logic src_match(input logic [4:0] dst, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic uses_rt);
    return (dst != REG_ZERO) && ((dst == rs) || (uses_rt && (dst == rt)));
  endfunction

endpackage

// File: rtl/mdu_busy_counter.sv
// Tracks how long the multi-cycle mult/div unit stays busy after a start leaves ID.
module mdu_busy_counter
  import semimips_hazard_pkg::*;
#(
  parameter int MDU_LATENCY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy
);

  localparam int CW = mdu_cnt_width(MDU_LATENCY);

  mdu_state_e      state;
  logic [CW-1:0]   cnt;

  // Starts are only accepted in RUN; a start while busy is always stalled upstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (start) begin
            state <= MDUWAIT;
            cnt   <= CW'(MDU_LATENCY);
            busy  <= 1'b1;
          end
        end
        MDUWAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= RUN;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= RUN;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/bubble generator for load-use, ID-resolved branch and busy-MDU hazards.
module hazard_stall_unit
  import semimips_hazard_pkg::*;
#(
  parameter int MDU_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       idrs,
  input  logic [4:0]       idrt,
  input  logic             idusesrt,
  input  logic             idbranch,
  input  logic             idmdustart,
  input  logic             idmduread,
  input  logic             idexmemrd,
  input  logic             idexregwr,
  input  logic [4:0]       idexregmuxout,
  input  logic             exmemmemrd,
  input  logic [4:0]       exmemregmuxout,
  output logic             pcwrite,
  output logic             ifidwrite,
  output logic             idexflush,
  output logic             mdubusy,
  output logic [CNT_W-1:0] stallcount
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic busy_q;
  logic idex_match;
  logic exmem_match;
  logic ld_haz;
  logic br_haz;
  logic mdu_haz;
  logic stall;

  assign idex_match  = src_match(idexregmuxout, idrs, idrt, idusesrt);
  assign exmem_match = src_match(exmemregmuxout, idrs, idrt, idusesrt);

  // Busy is forced low during reset so an abandoned MDU op never stalls anything.
  assign mdubusy = busy_q & ~rst;

  assign ld_haz  = idexmemrd & idex_match;
  assign br_haz  = idbranch & ((idexregwr & idex_match) | (exmemmemrd & exmem_match));
  assign mdu_haz = mdubusy & (idmduread | idmdustart);
  assign stall   = ld_haz | br_haz | mdu_haz;

  assign pcwrite   = ~(stall | rst);
  assign ifidwrite = ~(stall | rst);
  assign idexflush = stall | rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      stallcount <= '0;
    end else if (stall && (stallcount != CNT_MAX)) begin
      stallcount <= stallcount + CNT_W'(1);
    end
  end

  mdu_busy_counter #(
    .MDU_LATENCY(MDU_LATENCY)
  ) u_mdu_busy_counter (
    .clk  (clk),
    .rst  (rst),
    .start(idmdustart & ~stall),
    .busy (busy_q)
  );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed pipeline scenarios plus random traffic vs a remaining-cycles model.
module tb_hazard_stall_unit;

  localparam int LAT  = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    idrs, idrt, idexregmuxout, exmemregmuxout;
  logic          idusesrt, idbranch, idmdustart, idmduread;
  logic          idexmemrd, idexregwr, exmemmemrd;
  logic          pcwrite, ifidwrite, idexflush, mdubusy;
  logic [CW-1:0] stallcount;

  int vectors = 0;
  int miscompares = 0;
  int m_busy_left;
  int m_count;

  hazard_stall_unit #(.MDU_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .idrs(idrs), .idrt(idrt), .idusesrt(idusesrt),
    .idbranch(idbranch), .idmdustart(idmdustart), .idmduread(idmduread),
    .idexmemrd(idexmemrd), .idexregwr(idexregwr), .idexregmuxout(idexregmuxout),
    .exmemmemrd(exmemmemrd), .exmemregmuxout(exmemregmuxout),
    .pcwrite(pcwrite), .ifidwrite(ifidwrite), .idexflush(idexflush),
    .mdubusy(mdubusy), .stallcount(stallcount)
  );

  always #5 clk = ~clk;

  function automatic logic depends_on(input logic [4:0] dst);
    return dst != 5'd0 && (dst == idrs || (idusesrt && dst == idrt));
  endfunction

  function automatic logic model_stall();
    logic ld, br, mh;
    ld = idexmemrd && depends_on(idexregmuxout);
    br = idbranch && ((idexregwr && depends_on(idexregmuxout)) ||
                      (exmemmemrd && depends_on(exmemregmuxout)));
    mh = (m_busy_left > 0) && (idmduread || idmdustart);
    return ld || br || mh;
  endfunction

  // {pcwrite, ifidwrite, idexflush, mdubusy, stallcount} expected for the current cycle
  function automatic logic [CW+3:0] model_outputs();
    logic s, b;
    s = rst ? 1'b1 : model_stall();
    b = !rst && (m_busy_left > 0);
    return {~s, ~s, s, b, CW'(m_count)};
  endfunction

  task automatic clear_inputs();
    idrs = 0; idrt = 0; idusesrt = 0; idbranch = 0; idmdustart = 0; idmduread = 0;
    idexmemrd = 0; idexregwr = 0; idexregmuxout = 0; exmemmemrd = 0; exmemregmuxout = 0;
  endtask

  task automatic tick();
    logic s;
    s = model_stall();
    if (rst) begin
      m_busy_left = 0;
      m_count = 0;
    end else begin
      if (s && m_count < CMAX) m_count++;
      if (m_busy_left > 0) m_busy_left--;
      else if (idmdustart && !s) m_busy_left = LAT;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({pcwrite, ifidwrite, idexflush, mdubusy, stallcount} !== {4'b1100, CW'(0)}) begin
      miscompares++;
      $display("[TB] FAIL reset_state got %b want %b",
               {pcwrite, ifidwrite, idexflush, mdubusy, stallcount}, {4'b1100, CW'(0)});
    end
  endtask

  task automatic test_load_use();
    do_reset();
    idexmemrd = 1; idexregmuxout = 5'd2; idrs = 5'd2; idrt = 5'd4; idusesrt = 1;
    #1;
    vectors++;
    if ({pcwrite, ifidwrite, idexflush} !== 3'b001) begin
      miscompares++;
      $display("[TB] FAIL load_use_stall got %b want 001", {pcwrite, ifidwrite, idexflush});
    end
    tick();
    idexmemrd = 0; idexregmuxout = 0; exmemmemrd = 1; exmemregmuxout = 5'd2;
    #1;
    vectors++;
    if ({pcwrite, ifidwrite, idexflush, stallcount} !== {3'b110, CW'(1)}) begin
      miscompares++;
      $display("[TB] FAIL load_use_release got %b want %b",
               {pcwrite, ifidwrite, idexflush, stallcount}, {3'b110, CW'(1)});
    end
    tick();
  endtask

  task automatic test_no_hazard();
    do_reset();
    idexmemrd = 1; idexregmuxout = 5'd0; idrs = 5'd0; idrt = 5'd0; idusesrt = 1;
    #1;
    vectors++;
    if (idexflush !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reg_zero_load got %b want 0", idexflush);
    end
    idexregmuxout = 5'd5; idrs = 5'd3; idrt = 5'd5; idusesrt = 0;
    #1;
    vectors++;
    if (pcwrite !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rt_unused got %b want 1", pcwrite);
    end
    tick();
  endtask

  task automatic test_branch();
    int stalls;
    do_reset();
    stalls = 0;
    idbranch = 1; idrs = 5'd7; idrt = 5'd1; idusesrt = 1;
    idexmemrd = 1; idexregwr = 1; idexregmuxout = 5'd7;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (idexflush === 1'b1) stalls++;
      if (pcwrite === 1'b1) begin
        tick();
        break;
      end
      tick();
      // pipeline advances only the back end while ID is frozen
      exmemmemrd = idexmemrd; exmemregmuxout = idexregmuxout;
      idexmemrd = 0; idexregwr = 0; idexregmuxout = 0;
    end
    vectors++;
    if (stalls != 2) begin
      miscompares++;
      $display("[TB] FAIL branch_after_load got %0d stalls want 2", stalls);
    end
    clear_inputs();
    stalls = 0;
    idbranch = 1; idrs = 5'd7; idrt = 5'd1; idusesrt = 1;
    idexregwr = 1; idexregmuxout = 5'd7;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (idexflush === 1'b1) stalls++;
      if (pcwrite === 1'b1) begin
        tick();
        break;
      end
      tick();
      exmemmemrd = idexmemrd; exmemregmuxout = idexregmuxout;
      idexmemrd = 0; idexregwr = 0; idexregmuxout = 0;
    end
    vectors++;
    if (stalls != 1) begin
      miscompares++;
      $display("[TB] FAIL branch_after_alu got %0d stalls want 1", stalls);
    end
    clear_inputs();
  endtask

  task automatic test_mdu();
    logic [3:0] seen;
    do_reset();
    idmdustart = 1;
    #1;
    vectors++;
    if (pcwrite !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mult_start got %b want 1", pcwrite);
    end
    tick();
    idmdustart = 0;
    #1;
    vectors++;
    if (mdubusy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL busy_t1 got %b want 1", mdubusy);
    end
    tick();
    idmduread = 1;
    for (int c = 0; c < 4; c++) begin
      #1;
      seen[c] = idexflush;
      tick();
    end
    vectors++;
    if (seen !== 4'b0111) begin
      miscompares++;
      $display("[TB] FAIL mflo_stall_pattern got %b want 0111 (bit0=t+2)", seen);
    end
    vectors++;
    if (stallcount !== CW'(3)) begin
      miscompares++;
      $display("[TB] FAIL mflo_stallcount got %0d want 3", stallcount);
    end
    clear_inputs();
  endtask

  task automatic test_overlap();
    do_reset();
    idmdustart = 1;
    tick();
    idmdustart = 0; idmduread = 1;
    idexmemrd = 1; idexregmuxout = 5'd9; idrs = 5'd9;
    #1;
    vectors++;
    if (idexflush !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL overlap_stall got %b want 1", idexflush);
    end
    tick();
    clear_inputs();
    #1;
    vectors++;
    if (stallcount !== CW'(1)) begin
      miscompares++;
      $display("[TB] FAIL overlap_count got %0d want 1", stallcount);
    end
    repeat (LAT) tick();
  endtask

  task automatic test_reset_mid_mdu();
    do_reset();
    idmdustart = 1;
    tick();
    idmdustart = 0;
    tick();
    rst = 1; idmduread = 1;
    #1;
    vectors++;
    if ({pcwrite, ifidwrite, idexflush, mdubusy} !== 4'b0010) begin
      miscompares++;
      $display("[TB] FAIL in_reset got %b want 0010", {pcwrite, ifidwrite, idexflush, mdubusy});
    end
    tick();
    rst = 0;
    #1;
    vectors++;
    if ({pcwrite, idexflush, mdubusy, stallcount} !== {3'b100, CW'(0)}) begin
      miscompares++;
      $display("[TB] FAIL after_reset got %b want %b",
               {pcwrite, idexflush, mdubusy, stallcount}, {3'b100, CW'(0)});
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    idexmemrd = 1; idexregmuxout = 5'd3; idrs = 5'd3;
    repeat (CMAX + 5) tick();
    vectors++;
    if (stallcount !== CW'(CMAX)) begin
      miscompares++;
      $display("[TB] FAIL saturate got %0d want %0d", stallcount, CMAX);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    logic [CW+3:0] want;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      idrs = 5'($urandom_range(0, 3)); idrt = 5'($urandom_range(0, 3));
      idexregmuxout = 5'($urandom_range(0, 3)); exmemregmuxout = 5'($urandom_range(0, 3));
      idusesrt = 1'($urandom); idbranch = 1'($urandom);
      idmdustart = ($urandom_range(0, 5) == 0); idmduread = ($urandom_range(0, 3) == 0);
      idexmemrd = 1'($urandom); idexregwr = 1'($urandom); exmemmemrd = 1'($urandom);
      #1;
      want = model_outputs();
      vectors++;
      if ({pcwrite, ifidwrite, idexflush, mdubusy, stallcount} !== want) begin
        miscompares++;
        $display("[TB] FAIL random_%0d got %b want %b", n,
                 {pcwrite, ifidwrite, idexflush, mdubusy, stallcount}, want);
      end
      tick();
    end
    rst = 0;
    clear_inputs();
  endtask

  initial begin
    m_busy_left = 0;
    m_count = 0;
    rst = 1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch();
    test_mdu();
    test_overlap();
    test_reset_mid_mdu();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
